// File: rtl/shared_div_arbiter.sv
`timescale 1ns/1ps
// shared_div_arbiter
//  One iterative restoring divider (unsigned quotient + remainder) shared by
//  NUM_REQ requesters under round-robin arbitration. One operation is in flight
//  at a time; results come back on a single response channel tagged with the
//  index of the requester that was served.
//
// Ports
//  clk, rst_n        clock (rising edge), asynchronous active-low reset
//  req_valid[i]      requester i has an operation pending
//  req_ready[i]      one-hot grant (all zero unless idle)
//  req_dividend      packed operands, slice i = [i*WIDTH +: WIDTH]
//  req_divisor       packed operands, same slicing
//  rsp_valid         result available
//  rsp_ready         consumer takes the result
//  rsp_id            index of the served requester
//  rsp_quotient      dividend / divisor (all ones on divide-by-zero)
//  rsp_remainder     dividend % divisor (dividend on divide-by-zero)
//  rsp_div_by_zero   divisor was zero
//  busy              an operation is in flight or its result is pending
//  dbg_state         current FSM state (IDLE=0, DIVIDE=1, DONE=2)
//
// Handshakes: a transfer happens on a rising edge where valid and ready are
//  both high. Requesters hold valid and operands stable until ready; the
//  response holds all rsp_* stable from rsp_valid until rsp_ready. req_ready
//  depends only on req_valid and registered state, never on rsp_ready.
module shared_div_arbiter #(
  parameter int WIDTH   = 16,
  parameter int NUM_REQ = 4,
  localparam int IDX_W  = $clog2(NUM_REQ)
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [NUM_REQ-1:0]         req_valid,
  output logic [NUM_REQ-1:0]         req_ready,
  input  logic [NUM_REQ*WIDTH-1:0]   req_dividend,
  input  logic [NUM_REQ*WIDTH-1:0]   req_divisor,
  output logic                       rsp_valid,
  input  logic                       rsp_ready,
  output logic [IDX_W-1:0]           rsp_id,
  output logic [WIDTH-1:0]           rsp_quotient,
  output logic [WIDTH-1:0]           rsp_remainder,
  output logic                       rsp_div_by_zero,
  output logic                       busy,
  output logic [1:0]                 dbg_state
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [IDX_W:0] NUM_REQ_X = (IDX_W+1)'(NUM_REQ);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_DIVIDE = 2'd1,
    S_DONE   = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_next;
  logic [IDX_W-1:0] r_rr_ptr;
  logic [IDX_W-1:0] r_id;
  logic [WIDTH-1:0] r_quo;   // dividend shifts out MSB-first, quotient shifts in
  logic [WIDTH-1:0] r_rem;
  logic [WIDTH-1:0] r_dvs;
  logic [CNT_W-1:0] r_cnt;
  logic             r_dbz;
  logic             r_rsp_valid;
  logic             r_busy;

  // Round-robin search starting one past the last served requester.
  logic [NUM_REQ-1:0] w_grant;
  logic [IDX_W-1:0]   w_grant_idx;
  logic               w_found;
  logic [IDX_W:0]     w_scan;
  logic               w_accept;

  always_comb begin
    w_grant     = '0;
    w_grant_idx = '0;
    w_found     = 1'b0;
    w_scan      = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      w_scan = {1'b0, r_rr_ptr} + (IDX_W+1)'(k);
      if (w_scan >= NUM_REQ_X) w_scan = w_scan - NUM_REQ_X;
      if (!w_found && req_valid[w_scan[IDX_W-1:0]]) begin
        w_found     = 1'b1;
        w_grant_idx = w_scan[IDX_W-1:0];
      end
    end
    if (w_found && (r_state == S_IDLE)) w_grant[w_grant_idx] = 1'b1;
  end

  assign w_accept  = w_found && (r_state == S_IDLE);
  assign req_ready = w_grant;

  // Operand mux for the granted requester.
  logic [WIDTH-1:0] w_sel_dividend;
  logic [WIDTH-1:0] w_sel_divisor;

  always_comb begin
    w_sel_dividend = '0;
    w_sel_divisor  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (w_grant_idx == IDX_W'(i)) begin
        w_sel_dividend = req_dividend[i*WIDTH +: WIDTH];
        w_sel_divisor  = req_divisor[i*WIDTH +: WIDTH];
      end
    end
  end

  // One restoring step. The shifted partial remainder needs WIDTH+1 bits
  // because 2*rem+1 can exceed WIDTH bits when rem is close to a large divisor.
  // The difference goes negative (MSB set) exactly when the divisor does not fit.
  logic [WIDTH:0] w_shift;
  logic [WIDTH:0] w_diff;
  logic           w_fits;

  assign w_shift = {r_rem, r_quo[WIDTH-1]};
  assign w_diff  = w_shift - {1'b0, r_dvs};
  assign w_fits  = ~w_diff[WIDTH];

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:   if (w_accept) w_state_next = (w_sel_divisor == '0) ? S_DONE : S_DIVIDE;
      S_DIVIDE: if (r_cnt == '0) w_state_next = S_DONE;
      S_DONE:   if (rsp_ready) w_state_next = S_IDLE;
      default:  w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_next;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rr_ptr    <= IDX_W'(NUM_REQ-1);
      r_id        <= '0;
      r_quo       <= '0;
      r_rem       <= '0;
      r_dvs       <= '0;
      r_cnt       <= '0;
      r_dbz       <= 1'b0;
      r_rsp_valid <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      // Status flags track the next state so they come straight from flops.
      r_rsp_valid <= (w_state_next == S_DONE);
      r_busy      <= (w_state_next != S_IDLE);
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_id     <= w_grant_idx;
            r_rr_ptr <= w_grant_idx;
            r_dvs    <= w_sel_divisor;
            r_cnt    <= CNT_W'(WIDTH-1);
            if (w_sel_divisor == '0) begin
              r_quo <= '1;
              r_rem <= w_sel_dividend;
              r_dbz <= 1'b1;
            end else begin
              r_quo <= w_sel_dividend;
              r_rem <= '0;
              r_dbz <= 1'b0;
            end
          end
        end
        S_DIVIDE: begin
          r_rem <= w_fits ? w_diff[WIDTH-1:0] : w_shift[WIDTH-1:0];
          r_quo <= {r_quo[WIDTH-2:0], w_fits};
          r_cnt <= r_cnt - 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign rsp_valid       = r_rsp_valid;
  assign busy            = r_busy;
  assign rsp_id          = r_id;
  assign rsp_quotient    = r_quo;
  assign rsp_remainder   = r_rem;
  assign rsp_div_by_zero = r_dbz;
  assign dbg_state       = r_state;

endmodule
